cam_emulator: RTL and testbench
===============================

# cam_emulator

Synthetic DVP camera source that drives the same 8-bit pixel/href/cam_vsync stream the `Camera` capture block and `Buffer` consume from the sensor header. It is the transmitter side of the camera interface. It lets the capture path and the VGA display be brought up and regression-tested without a physical sensor. It runs on one pixel clock and emits whole frames of programmable test patterns with sensor-like vertical and horizontal blanking.

## Interface
Parameters:
- H_ACTIVE, 640, pixels (href-high cycles) per active line
- H_BLANK, 144, href-low cycles per line; LINE_LEN = H_ACTIVE + H_BLANK ≤ 1024
- VSYNC_LINES, 3, lines with cam_vsync high
- V_BACK, 17, blank lines after vsync
- V_ACTIVE, 480, active lines
- V_FRONT, 10, blank lines after active region; total lines ≤ 1024

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  allow frame generation; sampled only at frame boundaries
- pattern  in  2  test pattern select; latched at frame start
- pixel  out  8  pixel byte, valid when href=1
- href  out  1  active-line qualifier
- cam_vsync  out  1  frame sync, active high
- frame_done  out  1  one-cycle pulse on the last cycle of a frame
- frame_cnt  out  8  completed-frame count, wraps 255→0

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Counters: hcnt (0..LINE_LEN-1), vcnt (lines within the current state), and x, y (10 bits each).
- IDLE: all outputs low. If enable=1, the block goes to VSYNC on the next edge. It latches `pattern` on that edge and clears hcnt and vcnt.
- VSYNC: cam_vsync=1 for VSYNC_LINES·LINE_LEN cycles, then the block goes to VBACK.
- VBACK: outputs low for V_BACK·LINE_LEN cycles, then the block goes to ACTIVE.
- ACTIVE, per line: href=1 for hcnt < H_ACTIVE with x=hcnt, then href=0 for H_BLANK cycles. y = active line index. After V_ACTIVE lines the block goes to VFRONT.
- VFRONT: outputs low for V_FRONT·LINE_LEN cycles.
  - On its last cycle, frame_done=1 and frame_cnt increments.
  - If enable=1 on that cycle, the block goes straight to VSYNC (back-to-back frames, pattern re-latched). Otherwise it returns to IDLE.
- Deasserting enable mid-frame has no effect until the frame completes. Frames are never truncated.
- Patterns, using the latched value (all arithmetic mod 256):
  - 0: x[7:0]
  - 1: y[7:0]
  - 2: {8{x[3]^y[3]}}
  - 3: frame_cnt + x[7:0] + y[7:0]
- pixel = 0 whenever href=0.

## Timing
- All outputs are registered. Reset values: pixel=0, href=0, cam_vsync=0, frame_done=0, frame_cnt=0, state=IDLE, counters 0.
- Reset mid-frame: on the next edge the block is in IDLE with all outputs low. No partial-frame completion and no frame_done.
- Edge timing:
  - enable is sampled high in IDLE at edge N.
  - cam_vsync=1 is visible after edge N+1.
  - The first href=1 (x=0, y=0) appears exactly (VSYNC_LINES+V_BACK)·LINE_LEN cycles after cam_vsync rises.
- Each href pulse is exactly H_ACTIVE cycles wide. Successive href rising edges are LINE_LEN cycles apart.
- Frame period = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)·LINE_LEN cycles. With back-to-back frames, cam_vsync rises the cycle after frame_done.
- cam_vsync and href are never high simultaneously.
- frame_cnt updates on the same edge that asserts frame_done.
- Pattern 3 uses the pre-increment frame_cnt for the entire frame.

## Configuration
- CAM_EMU_CROSSHAIR_EN defined: pixel is forced to 8'hFF on active pixels where x == H_ACTIVE/2 or y == V_ACTIVE/2, overriding every pattern.
- Macro undefined: no overlay; the pattern output is unmodified.

## Test plan
Bench parameters: H_ACTIVE=8, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_ACTIVE=4, V_FRONT=1. This gives LINE_LEN=12 and a frame of 84 cycles.
- Reset with enable=1, then release: cam_vsync high for 12 cycles. First href rises 24 cycles after cam_vsync rises. 4 href pulses of 8 cycles each, 12 cycles apart. frame_done pulses once at cycle 84. frame_cnt=1.
- pattern=0, 2 frames: pixel sequence 0..7 on every line. With pattern=2: all 0x00 on lines 0–3, since x[3]=y[3]=0.
- pattern=3 held for 3 frames: first pixel of frame k (x=0, y=0) equals k−1. At frame 2, line 1, x=5 → pixel=0x07.
- enable dropped at cycle 30 of a frame: the frame completes, frame_done fires at cycle 84, then the block is in IDLE with outputs low. pattern changed mid-frame does not alter the pixels of the current frame.
- reset asserted during ACTIVE: href, cam_vsync and pixel are 0 after the next edge. No frame_done. frame_cnt=0.
- 256 frames back-to-back: frame_cnt wraps 255→0. There is no gap cycle between frame_done and the next cam_vsync. With CAM_EMU_CROSSHAIR_EN defined, pixel=0xFF at x=4 and throughout line y=2.

Source files
------------

// File: rtl/cam_emulator.sv
// Synthetic DVP camera source: emits framed test patterns with sensor-like blanking on pclk.
// Define CAM_EMU_CROSSHAIR_EN to overlay a white crosshair at the centre column and row.
module cam_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern,
    output logic [7:0] pixel,
    output logic       href,
    output logic       cam_vsync,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LINE_LEN = H_ACTIVE + H_BLANK;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t     state_q, state_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [1:0] pat_q, pat_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] pixel_q, pixel_d;
    logic       href_q, href_d;
    logic       cam_vsync_q, cam_vsync_d;
    logic       frame_done_q, frame_done_d;

    logic [9:0] n_lines;
    logic       line_end;
    logic       state_end;

    function automatic logic [7:0] pattern_pixel(input logic [1:0] p, input logic [7:0] x,
                                                 input logic [7:0] y, input logic [7:0] fc);
        logic [7:0] r;
        case (p)
            2'd0:    r = x;
            2'd1:    r = y;
            2'd2:    r = {8{x[3] ^ y[3]}};
            default: r = fc + x + y;
        endcase
        return r;
    endfunction

    always_comb begin
        n_lines = 10'(VSYNC_LINES);
        case (state_q)
            S_VBACK:  n_lines = 10'(V_BACK);
            S_ACTIVE: n_lines = 10'(V_ACTIVE);
            S_VFRONT: n_lines = 10'(V_FRONT);
            default:  n_lines = 10'(VSYNC_LINES);
        endcase
        line_end  = (hcnt_q == 10'(LINE_LEN - 1));
        state_end = line_end && (vcnt_q == n_lines - 10'd1);

        state_d      = state_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        pat_d        = pat_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern;
                hcnt_d  = 10'd0;
                vcnt_d  = 10'd0;
            end
        end else begin
            hcnt_d = line_end ? 10'd0 : hcnt_q + 10'd1;
            if (line_end)
                vcnt_d = state_end ? 10'd0 : vcnt_q + 10'd1;
            if (state_end) begin
                case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    default: begin
                        // Frame boundary: the only place enable and pattern are honoured mid-run.
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        if (enable) begin
                            state_d = S_VSYNC;
                            pat_d   = pattern;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                endcase
            end
        end

        cam_vsync_d = (state_q == S_VSYNC);
        href_d      = (state_q == S_ACTIVE) && (hcnt_q < 10'(H_ACTIVE));
        pixel_d     = 8'd0;
        if (href_d) begin
            pixel_d = pattern_pixel(pat_q, hcnt_q[7:0], vcnt_q[7:0], frame_cnt_q);
`ifdef CAM_EMU_CROSSHAIR_EN
            if (hcnt_q == 10'(H_ACTIVE / 2) || vcnt_q == 10'(V_ACTIVE / 2))
                pixel_d = 8'hFF;
`else
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hcnt_q       <= 10'd0;
            vcnt_q       <= 10'd0;
            pat_q        <= 2'd0;
            frame_cnt_q  <= 8'd0;
            frame_done_q <= 1'b0;
            pixel_q      <= 8'd0;
            href_q       <= 1'b0;
            cam_vsync_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            pat_q        <= pat_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            pixel_q      <= pixel_d;
            href_q       <= href_d;
            cam_vsync_q  <= cam_vsync_d;
        end
    end

    assign pixel      = pixel_q;
    assign href       = href_q;
    assign cam_vsync  = cam_vsync_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_emulator.sv
// Directed bench for cam_emulator with a small 8x4 frame (LINE_LEN=12, 84-cycle frame).
module tb_cam_emulator;

    logic       pclk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pattern;
    logic [7:0] pixel;
    logic       href;
    logic       cam_vsync;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    localparam int FRAME = 84;

    logic [7:0] c_pix [FRAME];
    logic       c_href[FRAME];
    logic       c_vs  [FRAME];
    logic       c_fd  [FRAME];
    logic [7:0] c_fc  [FRAME];

    cam_emulator #(
        .H_ACTIVE(8), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable), .pattern(pattern),
        .pixel(pixel), .href(href), .cam_vsync(cam_vsync),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Expected-value model, indexed by cycle i from the cam_vsync rise.
    function automatic bit exp_href_at(int i);
        return (i >= 24) && (i < 72) && (((i - 24) % 12) < 8);
    endfunction

    function automatic int x_at(int i);
        return (i - 24) % 12;
    endfunction

    function automatic int y_at(int i);
        return (i - 24) / 12;
    endfunction

    function automatic logic [7:0] exp_pix(int pat, int x, int y, int fc);
        logic [7:0] xv, yv, fv, r;
        xv = x[7:0];
        yv = y[7:0];
        fv = fc[7:0];
        case (pat)
            0:       r = xv;
            1:       r = yv;
            2:       r = {8{xv[3] ^ yv[3]}};
            default: r = fv + xv + yv;
        endcase
`ifdef CAM_EMU_CROSSHAIR_EN
        if (x == 4 || y == 2) r = 8'hFF;
`endif
        return r;
    endfunction

    task automatic wait_vs_rise(output int n);
        logic prev;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            prev = cam_vsync;
            tick();
            n++;
            if (!prev && cam_vsync) return;
        end
        n = -1;
    endtask

    task automatic capture_frame(input int drop_at);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) begin
                if (i == drop_at) begin
                    enable  = 1'b0;
                    pattern = 2'd0;
                end
                tick();
            end
            c_pix[i] = pixel; c_href[i] = href; c_vs[i] = cam_vsync;
            c_fd[i] = frame_done; c_fc[i] = frame_cnt;
        end
    endtask

    task automatic do_reset(input logic [1:0] pat);
        reset = 1'b1; enable = 1'b1; pattern = pat;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; pattern = 2'd0;
        tick(); tick(); tick();
        checks++; if (pixel !== 8'd0)    begin failures++; $display("FAIL reset_pixel got=%0h exp=0", pixel); end
        checks++; if (href !== 1'b0)     begin failures++; $display("FAIL reset_href got=%0b exp=0", href); end
        checks++; if (cam_vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%0b exp=0", cam_vsync); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%0b exp=0", frame_done); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_fc got=%0h exp=0", frame_cnt); end
    endtask

    task automatic test_frame_timing();
        int n;
        logic [7:0] ep;
        reset = 1'b0;
        wait_vs_rise(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL vsync_latency got=%0d exp=2", n); end
        if (n < 0) return;
        for (int f = 1; f <= 2; f++) begin
            capture_frame(-1);
            for (int i = 0; i < FRAME; i++) begin
                ep = exp_href_at(i) ? exp_pix(0, x_at(i), y_at(i), f - 1) : 8'd0;
                checks++; if (c_vs[i] !== (i < 12)) begin failures++; $display("FAIL timing_vs f=%0d i=%0d got=%0b exp=%0b", f, i, c_vs[i], i < 12); end
                checks++; if (c_href[i] !== exp_href_at(i)) begin failures++; $display("FAIL timing_href f=%0d i=%0d got=%0b exp=%0b", f, i, c_href[i], exp_href_at(i)); end
                checks++; if (c_fd[i] !== (i == 83)) begin failures++; $display("FAIL timing_fd f=%0d i=%0d got=%0b exp=%0b", f, i, c_fd[i], i == 83); end
                checks++; if (c_pix[i] !== ep) begin failures++; $display("FAIL pat0_pixel f=%0d i=%0d got=%0h exp=%0h", f, i, c_pix[i], ep); end
            end
            checks++; if (c_fc[82] !== 8'(f - 1)) begin failures++; $display("FAIL fc_before f=%0d got=%0d exp=%0d", f, c_fc[82], f - 1); end
            checks++; if (c_fc[83] !== 8'(f)) begin failures++; $display("FAIL fc_after f=%0d got=%0d exp=%0d", f, c_fc[83], f); end
            if (f == 1) begin
                wait_vs_rise(n);
                checks++; if (n !== 1) begin failures++; $display("FAIL no_gap got=%0d exp=1", n); end
                if (n < 0) return;
            end
        end
    endtask

    task automatic test_pattern2();
        int n;
        logic [7:0] ep;
        do_reset(2'd2);
        wait_vs_rise(n);
        checks++; if (n < 0) begin failures++; $display("FAIL pat2_start got=timeout exp=vsync"); return; end
        capture_frame(-1);
        for (int i = 24; i < 72; i++) begin
            ep = exp_href_at(i) ? exp_pix(2, x_at(i), y_at(i), 0) : 8'd0;
            checks++; if (c_pix[i] !== ep) begin failures++; $display("FAIL pat2_pixel i=%0d got=%0h exp=%0h", i, c_pix[i], ep); end
        end
    endtask

    task automatic test_pattern3();
        int n;
        logic [7:0] ep;
        do_reset(2'd3);
        for (int k = 1; k <= 3; k++) begin
            wait_vs_rise(n);
            checks++; if (n < 0) begin failures++; $display("FAIL pat3_start k=%0d got=timeout exp=vsync", k); return; end
            capture_frame(-1);
            ep = exp_pix(3, 0, 0, k - 1);
            checks++; if (c_pix[24] !== ep) begin failures++; $display("FAIL pat3_first k=%0d got=%0h exp=%0h", k, c_pix[24], ep); end
            for (int i = 24; i < 72; i++) begin
                ep = exp_href_at(i) ? exp_pix(3, x_at(i), y_at(i), k - 1) : 8'd0;
                checks++; if (c_pix[i] !== ep) begin failures++; $display("FAIL pat3_pixel k=%0d i=%0d got=%0h exp=%0h", k, i, c_pix[i], ep); end
            end
            if (k == 2) begin
                ep = exp_pix(3, 5, 1, 1);
                checks++; if (c_pix[41] !== ep) begin failures++; $display("FAIL pat3_f2_l1_x5 got=%0h exp=%0h", c_pix[41], ep); end
            end
        end
    endtask

    task automatic test_enable_drop();
        int n;
        logic [7:0] ep;
        bit seen_vs;
        do_reset(2'd1);
        wait_vs_rise(n);
        checks++; if (n < 0) begin failures++; $display("FAIL drop_start got=timeout exp=vsync"); return; end
        capture_frame(30);
        for (int i = 0; i < FRAME; i++) begin
            ep = exp_href_at(i) ? exp_pix(1, x_at(i), y_at(i), 0) : 8'd0;
            checks++; if (c_pix[i] !== ep) begin failures++; $display("FAIL drop_pixel i=%0d got=%0h exp=%0h", i, c_pix[i], ep); end
        end
        checks++; if (c_fd[83] !== 1'b1) begin failures++; $display("FAIL drop_fd got=%0b exp=1", c_fd[83]); end
        checks++; if (c_fc[83] !== 8'd1) begin failures++; $display("FAIL drop_fc got=%0d exp=1", c_fc[83]); end
        seen_vs = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (cam_vsync || href || frame_done || pixel != 8'd0) seen_vs = 1'b1;
        end
        checks++; if (seen_vs !== 1'b0) begin failures++; $display("FAIL drop_idle got=activity exp=quiet"); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit bad;
        do_reset(2'd0);
        wait_vs_rise(n);
        checks++; if (n < 0) begin failures++; $display("FAIL rmid_start got=timeout exp=vsync"); return; end
        repeat (40) tick();
        checks++; if (href !== 1'b1) begin failures++; $display("FAIL rmid_active got=%0b exp=1", href); end
        reset = 1'b1;
        tick();
        checks++; if (href !== 1'b0)      begin failures++; $display("FAIL rmid_href got=%0b exp=0", href); end
        checks++; if (cam_vsync !== 1'b0) begin failures++; $display("FAIL rmid_vsync got=%0b exp=0", cam_vsync); end
        checks++; if (pixel !== 8'd0)     begin failures++; $display("FAIL rmid_pixel got=%0h exp=0", pixel); end
        enable = 1'b0;
        reset  = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (frame_done || cam_vsync || href) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rmid_quiet got=activity exp=quiet"); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL rmid_fc got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_back_to_back_wrap();
        int n;
        logic [7:0] ep;
        do_reset(2'd3);
        for (int k = 1; k <= 256; k++) begin
            wait_vs_rise(n);
            if (k > 1) begin
                checks++; if (n !== 1) begin failures++; $display("FAIL b2b_gap k=%0d got=%0d exp=1", k, n); end
            end
            if (n < 0) begin
                checks++; failures++; $display("FAIL b2b_start k=%0d got=timeout exp=vsync", k);
                return;
            end
            capture_frame(-1);
            checks++; if (c_fd[83] !== 1'b1 || c_fc[83] !== 8'(k)) begin
                failures++; $display("FAIL b2b_fc k=%0d got=%0d/%0b exp=%0d/1", k, c_fc[83], c_fd[83], k % 256);
            end
        end
        ep = exp_pix(3, 4, 0, 255);
        checks++; if (c_pix[28] !== ep) begin failures++; $display("FAIL b2b_x4 got=%0h exp=%0h", c_pix[28], ep); end
        ep = exp_pix(3, 1, 2, 255);
        checks++; if (c_pix[49] !== ep) begin failures++; $display("FAIL b2b_y2 got=%0h exp=%0h", c_pix[49], ep); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL b2b_wrap got=%0d exp=0", frame_cnt); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pattern = 2'd0;
        test_reset();
        test_frame_timing();
        test_pattern2();
        test_pattern3();
        test_enable_drop();
        test_reset_mid_frame();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
